draw_rect_ctl: RTL and testbench

- Frame-synchronous position controller for the rectangle drawing stage; supplies `xpos`/`ypos` that the drawing stage uses in place of fixed start coordinates.
- Advances the rectangle once per N frames, bouncing off the active-area edges.
- Sits beside the timing/background/draw_rect chain, clocked by the pixel clock.
- Taps `vblnk` from the timing chain and is commanded by `start`/`stop` strobes, e.g. from buttons or a mouse block.

---
 rtl/draw_rect_ctl.sv | 186 ++++++++++++++++++
 tb/tb_draw_rect_ctl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_rect_ctl.sv
// Frame-synchronous rectangle position controller: steps xpos/ypos once per FRAME_DIV frames and bounces off the active-area edges.
// Optional macro DRAW_RECT_CTL_GRAVITY_EN replaces constant vertical steps with an accelerating/decelerating speed.
module draw_rect_ctl #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned V_ACTIVE  = 600,
  parameter int unsigned RECT_W    = 100,
  parameter int unsigned RECT_H    = 100,
  parameter int unsigned X_INIT    = 1,
  parameter int unsigned Y_INIT    = 1,
  parameter int unsigned STEP_X    = 4,
  parameter int unsigned STEP_Y    = 2,
  parameter int unsigned FRAME_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        start,
  input  logic        stop,
  input  logic        home,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        running,
  output logic        frame_tick
);

  localparam int unsigned POS_W = 12;
  localparam int unsigned SUM_W = POS_W + 1;
  localparam int unsigned XMAX  = H_ACTIVE - RECT_W;
  localparam int unsigned YMAX  = V_ACTIVE - RECT_H;
  localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned VY_W  = 6;
  localparam int unsigned VY_MAX = 31;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP} state_t;

  state_t             r_state, w_state_nxt;
  logic [POS_W-1:0]   r_xpos, r_ypos, w_xpos_nxt, w_ypos_nxt;
  logic               r_dir_x, r_dir_y, w_dir_x_nxt, w_dir_y_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_vblnk_d, r_frame_tick, r_running, w_running_nxt;
  logic [VY_W-1:0]    r_vy, w_vy_nxt;

  logic [POS_W-1:0]   w_x_step, w_y_step;
  logic               w_dx_step, w_dy_step;
  logic [VY_W-1:0]    w_vy_step;
  logic [SUM_W-1:0]   w_x_sum, w_y_sum;

  assign xpos       = r_xpos;
  assign ypos       = r_ypos;
  assign running    = r_running;
  assign frame_tick = r_frame_tick;

  // Candidate position for the next step, computed from the current registers.
  always_comb begin
    w_x_step  = r_xpos;
    w_dx_step = r_dir_x;
    w_y_step  = r_ypos;
    w_dy_step = r_dir_y;
    w_vy_step = r_vy;
    w_x_sum   = SUM_W'(r_xpos) + SUM_W'(STEP_X);
    w_y_sum   = '0;

    if (r_dir_x) begin
      if (w_x_sum >= SUM_W'(XMAX)) begin
        w_x_step  = POS_W'(XMAX);
        w_dx_step = 1'b0;
      end else begin
        w_x_step  = w_x_sum[POS_W-1:0];
      end
    end else if (r_xpos <= POS_W'(STEP_X)) begin
      w_x_step  = '0;
      w_dx_step = 1'b1;
    end else begin
      w_x_step  = r_xpos - POS_W'(STEP_X);
    end

`ifdef DRAW_RECT_CTL_GRAVITY_EN
    w_y_sum = SUM_W'(r_ypos) + SUM_W'(r_vy);
    if (r_dir_y) begin
      if (w_y_sum >= SUM_W'(YMAX)) begin
        w_y_step  = POS_W'(YMAX);
        w_dy_step = 1'b0;
      end else begin
        w_y_step  = w_y_sum[POS_W-1:0];
        w_vy_step = (r_vy >= VY_W'(VY_MAX)) ? VY_W'(VY_MAX) : r_vy + VY_W'(1);
      end
    end else begin
      w_y_step  = (r_ypos > POS_W'(r_vy)) ? r_ypos - POS_W'(r_vy) : '0;
      w_vy_step = (r_vy == '0) ? '0 : r_vy - VY_W'(1);
      w_dy_step = (w_vy_step == '0);
    end
`else
    w_y_sum = SUM_W'(r_ypos) + SUM_W'(STEP_Y);
    if (r_dir_y) begin
      if (w_y_sum >= SUM_W'(YMAX)) begin
        w_y_step  = POS_W'(YMAX);
        w_dy_step = 1'b0;
      end else begin
        w_y_step  = w_y_sum[POS_W-1:0];
      end
    end else if (r_ypos <= POS_W'(STEP_Y)) begin
      w_y_step  = '0;
      w_dy_step = 1'b1;
    end else begin
      w_y_step  = r_ypos - POS_W'(STEP_Y);
    end
`endif
  end

  // Next-state logic; home overrides everything, stop overrides start.
  always_comb begin
    w_state_nxt = r_state;
    w_xpos_nxt  = r_xpos;
    w_ypos_nxt  = r_ypos;
    w_dir_x_nxt = r_dir_x;
    w_dir_y_nxt = r_dir_y;
    w_cnt_nxt   = r_cnt;
    w_vy_nxt    = r_vy;

    case (r_state)
      S_IDLE: begin
        if (start && !stop) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_frame_tick) begin
          if (r_cnt == CNT_W'(FRAME_DIV - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_STEP;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
      end
      S_STEP: begin
        w_xpos_nxt  = w_x_step;
        w_ypos_nxt  = w_y_step;
        w_dir_x_nxt = w_dx_step;
        w_dir_y_nxt = w_dy_step;
        w_vy_nxt    = w_vy_step;
        w_state_nxt = stop ? S_IDLE : S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (home) begin
      w_state_nxt = S_IDLE;
      w_xpos_nxt  = POS_W'(X_INIT);
      w_ypos_nxt  = POS_W'(Y_INIT);
      w_dir_x_nxt = 1'b1;
      w_dir_y_nxt = 1'b1;
      w_cnt_nxt   = '0;
      w_vy_nxt    = '0;
    end

    w_running_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_xpos       <= POS_W'(X_INIT);
      r_ypos       <= POS_W'(Y_INIT);
      r_dir_x      <= 1'b1;
      r_dir_y      <= 1'b1;
      r_cnt        <= '0;
      r_vy         <= '0;
      r_vblnk_d    <= 1'b0;
      r_frame_tick <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_xpos       <= w_xpos_nxt;
      r_ypos       <= w_ypos_nxt;
      r_dir_x      <= w_dir_x_nxt;
      r_dir_y      <= w_dir_y_nxt;
      r_cnt        <= w_cnt_nxt;
      r_vy         <= w_vy_nxt;
      r_vblnk_d    <= vblnk;
      r_frame_tick <= vblnk & ~r_vblnk_d;
      r_running    <= w_running_nxt;
    end
  end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Scoreboard bench for draw_rect_ctl: default, edge-bounce and frame-divider instances share one stimulus stream.
module tb_draw_rect_ctl;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
  } pos_t;

  logic clk, rst, vblnk, start, stop, home;
  logic [11:0] dut_x, dut_y, bnc_x, bnc_y, div_x, div_y;
  logic dut_run, dut_tick, bnc_run, bnc_tick, div_run, div_tick;

  pos_t q_exp[$];
  int   n_cmp = 0;
  int   n_err = 0;

  draw_rect_ctl u_dut (
    .clk(clk), .rst(rst), .vblnk(vblnk), .start(start), .stop(stop), .home(home),
    .xpos(dut_x), .ypos(dut_y), .running(dut_run), .frame_tick(dut_tick)
  );

  draw_rect_ctl #(.X_INIT(698), .Y_INIT(497)) u_bnc (
    .clk(clk), .rst(rst), .vblnk(vblnk), .start(start), .stop(stop), .home(home),
    .xpos(bnc_x), .ypos(bnc_y), .running(bnc_run), .frame_tick(bnc_tick)
  );

  draw_rect_ctl #(.FRAME_DIV(3)) u_div (
    .clk(clk), .rst(rst), .vblnk(vblnk), .start(start), .stop(stop), .home(home),
    .xpos(div_x), .ypos(div_y), .running(div_run), .frame_tick(div_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic p, input logic h);
    start = s; stop = p; home = h;
    cyc(1);
    start = 1'b0; stop = 1'b0; home = 1'b0;
  endtask

  // Reference bounce model for one axis.
  task automatic axis(inout logic [11:0] p, inout logic d, input int lim, input int st);
    if (d) begin
      if (int'(p) + st >= lim) begin p = 12'(lim); d = 1'b0; end
      else p = p + 12'(st);
    end else begin
      if (int'(p) <= st) begin p = 12'd0; d = 1'b1; end
      else p = p - 12'(st);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vblnk = ~vblnk;
      cyc(1);
      n_cmp++; if (dut_x !== 12'd1) begin n_err++; $display("FAIL reset_x: got %0d expected 1", dut_x); end
      n_cmp++; if (dut_y !== 12'd1) begin n_err++; $display("FAIL reset_y: got %0d expected 1", dut_y); end
      n_cmp++; if (dut_run !== 1'b0) begin n_err++; $display("FAIL reset_running: got %0b expected 0", dut_run); end
      n_cmp++; if (dut_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %0b expected 0", dut_tick); end
    end
    n_cmp++; if (bnc_x !== 12'd698) begin n_err++; $display("FAIL reset_bnc_x: got %0d expected 698", bnc_x); end
    rst = 1'b0;
    vblnk = 1'b0;
    cyc(2);
  endtask

  task automatic test_basic();
    logic [11:0] x, y, px;
    logic dx, dy;
    pos_t e;
    x = 12'd1; y = 12'd1; dx = 1'b1; dy = 1'b1;
    q_exp.delete();
    pulse(1'b1, 1'b0, 1'b0);
    n_cmp++; if (dut_run !== 1'b1) begin n_err++; $display("FAIL basic_running: got %0b expected 1", dut_run); end
    for (int f = 0; f < 3; f++) begin
      px = x;
      axis(x, dx, 700, 4);
      axis(y, dy, 500, 2);
      q_exp.push_back('{x: x, y: y});
      vblnk = 1'b1;
      cyc(1);
      n_cmp++; if (dut_tick !== 1'b1) begin n_err++; $display("FAIL basic_tick: got %0b expected 1", dut_tick); end
      cyc(1);
      n_cmp++; if (dut_x !== px) begin n_err++; $display("FAIL basic_latency_x: got %0d expected %0d", dut_x, px); end
      n_cmp++; if (dut_tick !== 1'b0) begin n_err++; $display("FAIL basic_tick_pulse: got %0b expected 0", dut_tick); end
      cyc(1);
      e = q_exp.pop_front();
      n_cmp++; if (dut_x !== e.x) begin n_err++; $display("FAIL basic_x: got %0d expected %0d", dut_x, e.x); end
      n_cmp++; if (dut_y !== e.y) begin n_err++; $display("FAIL basic_y: got %0d expected %0d", dut_y, e.y); end
      vblnk = 1'b0;
      cyc(3);
    end
    n_cmp++; if (dut_x !== 12'd13 || dut_y !== 12'd7) begin
      n_err++; $display("FAIL basic_final: got (%0d,%0d) expected (13,7)", dut_x, dut_y);
    end
  endtask

  task automatic test_bounce();
    logic [11:0] x, y;
    logic dx, dy;
    pos_t e;
    x = 12'd698; y = 12'd497; dx = 1'b1; dy = 1'b1;
    q_exp.delete();
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++; if (bnc_x !== 12'd698 || bnc_y !== 12'd497) begin
      n_err++; $display("FAIL bounce_home: got (%0d,%0d) expected (698,497)", bnc_x, bnc_y);
    end
    pulse(1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) begin
      axis(x, dx, 700, 4);
      axis(y, dy, 500, 2);
      q_exp.push_back('{x: x, y: y});
      vblnk = 1'b1;
      cyc(3);
      e = q_exp.pop_front();
      n_cmp++; if (bnc_x !== e.x) begin n_err++; $display("FAIL bounce_x step %0d: got %0d expected %0d", f, bnc_x, e.x); end
      n_cmp++; if (bnc_y !== e.y) begin n_err++; $display("FAIL bounce_y step %0d: got %0d expected %0d", f, bnc_y, e.y); end
      vblnk = 1'b0;
      cyc(3);
    end
  endtask

  task automatic test_divider();
    logic [11:0] x, y, px, py;
    logic dx, dy;
    int changes;
    pos_t e;
    x = 12'd1; y = 12'd1; dx = 1'b1; dy = 1'b1;
    changes = 0;
    q_exp.delete();
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 6; f++) begin
      if (f % 3 == 2) begin
        axis(x, dx, 700, 4);
        axis(y, dy, 500, 2);
        q_exp.push_back('{x: x, y: y});
      end
      px = div_x; py = div_y;
      vblnk = 1'b1;
      for (int c = 0; c < 6; c++) begin
        if (c == 3) vblnk = 1'b0;
        cyc(1);
        if (div_x !== px || div_y !== py) begin
          changes++;
          n_cmp++;
          if (q_exp.size() == 0) begin
            n_err++; $display("FAIL div_unexpected: got (%0d,%0d) expected no change", div_x, div_y);
          end else begin
            e = q_exp.pop_front();
            if (div_x !== e.x || div_y !== e.y) begin
              n_err++; $display("FAIL div_pos: got (%0d,%0d) expected (%0d,%0d)", div_x, div_y, e.x, e.y);
            end
          end
          px = div_x; py = div_y;
        end
      end
    end
    n_cmp++; if (changes != 2) begin n_err++; $display("FAIL div_changes: got %0d expected 2", changes); end
    n_cmp++; if (q_exp.size() != 0) begin n_err++; $display("FAIL div_pending: got %0d expected 0", q_exp.size()); end
  endtask

  task automatic test_vblnk_hold();
    int ticks;
    ticks = 0;
    vblnk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (dut_tick === 1'b1) ticks++;
    end
    vblnk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (dut_tick === 1'b1) ticks++;
    end
    n_cmp++; if (ticks != 1) begin n_err++; $display("FAIL hold_ticks: got %0d expected 1", ticks); end
  endtask

  task automatic test_stop_in_step();
    pos_t e;
    q_exp.delete();
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    q_exp.push_back('{x: 12'd5, y: 12'd3});
    vblnk = 1'b1;
    cyc(2);
    n_cmp++; if (dut_run !== 1'b1) begin n_err++; $display("FAIL stop_step_running: got %0b expected 1", dut_run); end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    e = q_exp.pop_front();
    n_cmp++; if (dut_x !== e.x || dut_y !== e.y) begin
      n_err++; $display("FAIL stop_step_pos: got (%0d,%0d) expected (%0d,%0d)", dut_x, dut_y, e.x, e.y);
    end
    n_cmp++; if (dut_run !== 1'b0) begin n_err++; $display("FAIL stop_step_idle: got %0b expected 0", dut_run); end
    vblnk = 1'b0;
    cyc(3);
    for (int f = 0; f < 4; f++) begin
      vblnk = 1'b1; cyc(3);
      vblnk = 1'b0; cyc(3);
      n_cmp++; if (dut_x !== 12'd5 || dut_y !== 12'd3) begin
        n_err++; $display("FAIL stop_frozen frame %0d: got (%0d,%0d) expected (5,3)", f, dut_x, dut_y);
      end
    end
  endtask

  task automatic test_start_stop();
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b1, 1'b0);
    n_cmp++; if (dut_run !== 1'b0) begin n_err++; $display("FAIL start_stop_running: got %0b expected 0", dut_run); end
    vblnk = 1'b1; cyc(3);
    vblnk = 1'b0; cyc(3);
    n_cmp++; if (dut_x !== 12'd1 || dut_y !== 12'd1) begin
      n_err++; $display("FAIL start_stop_pos: got (%0d,%0d) expected (1,1)", dut_x, dut_y);
    end
    pulse(1'b1, 1'b0, 1'b1);
    n_cmp++; if (dut_run !== 1'b0) begin n_err++; $display("FAIL start_home_running: got %0b expected 0", dut_run); end
  endtask

  task automatic test_home();
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    vblnk = 1'b1; cyc(3);
    vblnk = 1'b0; cyc(3);
    n_cmp++; if (dut_x !== 12'd5 || dut_y !== 12'd3) begin
      n_err++; $display("FAIL home_prerun: got (%0d,%0d) expected (5,3)", dut_x, dut_y);
    end
    vblnk = 1'b1;
    cyc(1);
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++; if (dut_x !== 12'd1 || dut_y !== 12'd1) begin
      n_err++; $display("FAIL home_pos: got (%0d,%0d) expected (1,1)", dut_x, dut_y);
    end
    n_cmp++; if (dut_run !== 1'b0) begin n_err++; $display("FAIL home_running: got %0b expected 0", dut_run); end
    vblnk = 1'b0;
    cyc(3);
    n_cmp++; if (dut_x !== 12'd1 || dut_y !== 12'd1) begin
      n_err++; $display("FAIL home_abort: got (%0d,%0d) expected (1,1)", dut_x, dut_y);
    end
  endtask

  initial begin
    rst = 1'b1; vblnk = 1'b0; start = 1'b0; stop = 1'b0; home = 1'b0;
    test_reset();
    test_basic();
    test_bounce();
    test_divider();
    test_vblnk_hold();
    test_stop_in_step();
    test_start_stop();
    test_home();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
